// File: rtl/button_pkg.sv
// button_pkg: shared repeat-state enum, 12 MHz board timing defaults and polarity mask.
package button_pkg;

    typedef enum logic [1:0] {RELEASED, HOLD_DELAY, HOLD_REPEAT} rpt_state_t;

    localparam int DEBOUNCE_20MS_12MHZ = 240000;
    localparam int REPEAT_DELAY_12MHZ = 6000000;
    localparam int REPEAT_RATE_12MHZ = 1200000;
    localparam logic [2:0] BTN_N_MASK = 3'b100;

    // Never narrower than one bit, even for tiny cycle counts.
    function automatic int cnt_width(input int n);
        return n <= 2 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button pins in, conditioned levels and pulses out.
interface button_conditioner_if #(parameter int N_BTN = 3);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    modport master(output btn_raw, input btn_level, press_pulse, release_pulse, repeat_pulse);
    modport slave(input btn_raw, output btn_level, press_pulse, release_pulse, repeat_pulse);
endinterface

// File: rtl/button_channel.sv
// button_channel: one button's synchroniser, debouncer, repeat FSM and pulse registers.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_12MHZ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_12MHZ,
    parameter int REPEAT_RATE = REPEAT_RATE_12MHZ,
    parameter logic ACTIVE_LOW = 1'b0,
    parameter logic REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls,
    output logic rpt
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [1:0] sync;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rpt_cnt;
    rpt_state_t state;
    logic flip;
    logic rpt_hit;

    always_comb flip = (sync[1] != level) && (cnt == DEB_LAST);
    always_comb rpt_hit = rpt_cnt == (state == HOLD_DELAY ? DELAY_LAST : RATE_LAST);

    // A debounced edge takes priority over repeat ticks, so a repeat never
    // coincides with a press or release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls <= 1'b0;
            rpt <= 1'b0;
            rpt_cnt <= '0;
            state <= RELEASED;
        end else begin
            sync <= {sync[0], raw ^ ACTIVE_LOW};
            cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
            level <= level ^ flip;
            press <= flip & ~level;
            rls <= flip & level;
            rpt <= 1'b0;
            if (flip) begin
                state <= level ? RELEASED : HOLD_DELAY;
                rpt_cnt <= '0;
            end else if (state != RELEASED) begin
                if (rpt_hit) begin
                    rpt <= REPEAT_EN;
                    rpt_cnt <= '0;
                    state <= HOLD_REPEAT;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent button channels with per-bit polarity and repeat enables.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_12MHZ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_12MHZ,
    parameter int REPEAT_RATE = REPEAT_RATE_12MHZ,
    parameter logic [N_BTN-1:0] ACTIVE_LOW = '0,
    parameter logic [N_BTN-1:0] REPEAT_EN = '1
) (
    input logic CLK,
    input logic RST_N,
    button_conditioner_if.slave bus
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE(REPEAT_RATE),
            .ACTIVE_LOW(ACTIVE_LOW[i]),
            .REPEAT_EN(REPEAT_EN[i])
        ) u_ch (
            .clk(CLK),
            .rst_n(RST_N),
            .raw(bus.btn_raw[i]),
            .level(bus.btn_level[i]),
            .press(bus.press_pulse[i]),
            .rls(bus.release_pulse[i]),
            .rpt(bus.repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed edge-accurate checks of debounce, pulses, repeat and reset.
module tb_button_conditioner;

    logic CLK;
    logic RST_N;
    int errors = 0;
    int checks = 0;
    int prs_cnt [3] = '{0, 0, 0};
    int rel_cnt [3] = '{0, 0, 0};
    int rep_cnt [3] = '{0, 0, 0};
    int snap;

    button_conditioner_if #(.N_BTN(3)) bus ();

    button_conditioner #(
        .N_BTN(3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(3),
        .ACTIVE_LOW(3'b100),
        .REPEAT_EN(3'b011)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse tallies, sampled mid-cycle away from the active edge.
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            prs_cnt[k] += int'(bus.press_pulse[k]);
            rel_cnt[k] += int'(bus.release_pulse[k]);
            rep_cnt[k] += int'(bus.repeat_pulse[k]);
        end
    end

    function automatic logic [31:0] o(input logic [2:0] lv, pr, rl, rp);
        return {20'd0, lv, pr, rl, rp};
    endfunction

    function automatic logic [31:0] outs();
        return {20'd0, bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        bus.btn_raw = 3'b100;
        cyc(3);
        chk("in_reset", outs(), o(0, 0, 0, 0));
        RST_N = 1'b1;
        cyc(2);
        chk("after_reset_al_idle", outs(), o(0, 0, 0, 0));

        // Clean press on ch0: level and press visible after edge 6.
        bus.btn_raw = 3'b101;
        cyc(5);
        chk("press_edge5", outs(), o(0, 0, 0, 0));
        cyc(1);
        chk("press_edge6", outs(), o(3'b001, 3'b001, 0, 0));
        cyc(1);
        chk("press_edge7", outs(), o(3'b001, 0, 0, 0));
        cyc(8);
        chk("rpt_edge15", outs(), o(3'b001, 0, 0, 0));
        cyc(1);
        chk("rpt_first_P10", outs(), o(3'b001, 0, 0, 3'b001));
        cyc(2);
        chk("rpt_gap", outs(), o(3'b001, 0, 0, 0));
        cyc(1);
        chk("rpt_P13", outs(), o(3'b001, 0, 0, 3'b001));
        cyc(3);
        chk("rpt_P16", outs(), o(3'b001, 0, 0, 3'b001));

        // Release: repeat tick at edge 25 still fires, edge 28 is release only.
        bus.btn_raw = 3'b100;
        cyc(3);
        chk("rpt_P19", outs(), o(3'b001, 0, 0, 3'b001));
        cyc(2);
        chk("pre_release", outs(), o(3'b001, 0, 0, 0));
        cyc(1);
        chk("release_no_rpt", outs(), o(0, 0, 3'b001, 0));
        cyc(1);
        chk("release_done", outs(), o(0, 0, 0, 0));
        snap = rep_cnt[0];
        cyc(10);
        chk("no_rpt_after_release", 32'(rep_cnt[0] - snap), 32'd0);
        chk("single_release", 32'(rel_cnt[0]), 32'd1);

        // Bounce: 3 high, 1 low, 3 high never reaches the 4-cycle threshold.
        snap = prs_cnt[0];
        bus.btn_raw = 3'b101;
        cyc(3);
        bus.btn_raw = 3'b100;
        cyc(1);
        bus.btn_raw = 3'b101;
        cyc(3);
        bus.btn_raw = 3'b100;
        cyc(10);
        chk("bounce_no_press", 32'(prs_cnt[0] - snap), 32'd0);
        chk("bounce_idle", outs(), o(0, 0, 0, 0));

        // Active-low ch2 pressed by driving 0; repeat disabled on it.
        bus.btn_raw = 3'b000;
        cyc(5);
        chk("al_edge5", outs(), o(0, 0, 0, 0));
        cyc(1);
        chk("al_press", outs(), o(3'b100, 3'b100, 0, 0));
        cyc(20);
        chk("al_no_repeat", 32'(rep_cnt[2]), 32'd0);
        chk("al_held", outs(), o(3'b100, 0, 0, 0));
        bus.btn_raw = 3'b100;
        cyc(6);
        chk("al_release", outs(), o(0, 0, 3'b100, 0));
        cyc(2);

        // Simultaneous press on ch0/ch1; ch0 releases during ch1's repeats.
        bus.btn_raw = 3'b111;
        cyc(5);
        chk("sim_edge5", outs(), o(0, 0, 0, 0));
        cyc(1);
        chk("sim_press", outs(), o(3'b011, 3'b011, 0, 0));
        cyc(10);
        chk("sim_rpt1", outs(), o(3'b011, 0, 0, 3'b011));
        bus.btn_raw = 3'b110;
        cyc(3);
        chk("sim_rpt2", outs(), o(3'b011, 0, 0, 3'b011));
        cyc(3);
        chk("sim_ch0_rel_ch1_rpt", outs(), o(3'b010, 0, 3'b001, 3'b010));
        cyc(3);
        chk("sim_ch1_rpt4", outs(), o(3'b010, 0, 0, 3'b010));
        cyc(1);
        chk("sim_ch1_gap", outs(), o(3'b010, 0, 0, 0));
        bus.btn_raw = 3'b100;
        cyc(6);
        chk("sim_ch1_release", outs(), o(0, 0, 3'b010, 0));
        cyc(2);

        // Reset while ch0 is in HOLD_REPEAT.
        bus.btn_raw = 3'b101;
        cyc(6);
        chk("rst_pre_press", outs(), o(3'b001, 3'b001, 0, 0));
        cyc(12);
        chk("rst_pre_level", outs(), o(3'b001, 0, 0, 0));
        snap = rel_cnt[0];
        RST_N = 1'b0;
        #1;
        chk("rst_async_clear", outs(), o(0, 0, 0, 0));
        cyc(2);
        chk("rst_held", outs(), o(0, 0, 0, 0));
        chk("rst_no_release", 32'(rel_cnt[0] - snap), 32'd0);
        RST_N = 1'b1;
        cyc(5);
        chk("rst_edge5", outs(), o(0, 0, 0, 0));
        cyc(1);
        chk("rst_repress", outs(), o(3'b001, 3'b001, 0, 0));
        cyc(9);
        chk("rst_pre_rpt", outs(), o(3'b001, 0, 0, 0));
        cyc(1);
        chk("rst_first_rpt", outs(), o(3'b001, 0, 0, 3'b001));
        chk("rst_no_release_total", 32'(rel_cnt[0] - snap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
